// File: rtl/pasta_pkg.sv
// Shared PASTA constants and types.
//  BITLEN  : lane width in bits
//  Q       : prime modulus (Q < 2**BITLEN)
//  PASTA_S : lanes per state vector
//  rc_state_t : sequencing states of the round-constant stage
//  lane_of : extract lane i from a packed state vector at the default geometry
package pasta_pkg;

  localparam int unsigned BITLEN  = 17;
  localparam int unsigned Q       = 65537;
  localparam int unsigned PASTA_S = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } rc_state_t;

  function automatic logic [BITLEN-1:0] lane_of(input logic [BITLEN*PASTA_S-1:0] v,
                                                input int unsigned i);
    return v[i*BITLEN +: BITLEN];
  endfunction

endpackage

// File: rtl/mod_addsub_lane.sv
// Single-lane modular adder/subtractor, purely combinational.
//  a, b : operands, expected in [0, Q-1]
//  mode : 0 -> r = (a + b) mod Q, 1 -> r = (a - b) mod Q
//  r    : result in [0, Q-1]
module mod_addsub_lane #(
  parameter int unsigned BITLEN = pasta_pkg::BITLEN,
  parameter int unsigned Q      = pasta_pkg::Q
) (
  input  logic [BITLEN-1:0] a,
  input  logic [BITLEN-1:0] b,
  input  logic              mode,
  output logic [BITLEN-1:0] r
);

  localparam logic [BITLEN:0] QW = (BITLEN+1)'(Q);

  logic [BITLEN:0] s;
  logic [BITLEN:0] d;

  always_comb begin
    s = {1'b0, a} + {1'b0, b};
    d = {1'b0, a} - {1'b0, b};
    r = '0;
    if (mode == 1'b0) begin
      r = (s >= QW) ? BITLEN'(s - QW) : s[BITLEN-1:0];
    end else begin
      // a < b wraps d modulo 2**(BITLEN+1); adding Q lands back in [0, Q-1]
      r = (a < b) ? BITLEN'(d + QW) : BITLEN'(d);
    end
  end

endmodule

// File: rtl/round_constant_seq.sv
// Sequential PASTA round-constant stage: out_rc = vec_in (+/-) in_rc mod Q, lane-wise,
// LANES lanes per cycle over PASTA_S/LANES cycles.
//  clk      : clock, rising edge
//  rst_rc   : synchronous active-high reset
//  start_rc : request, sampled only when not busy (IDLE or DONE)
//  mode_rc  : 0 add, 1 subtract; latched with start
//  vec_in   : state vector, lane i = [i*BITLEN +: BITLEN]; latched with start
//  in_rc    : round-constant vector, same packing; latched with start
//  out_rc   : registered result vector, written chunk by chunk
//  busy_rc  : high from start acceptance until done_rc
//  done_rc  : one-cycle pulse, out_rc complete
module round_constant_seq #(
  parameter int unsigned BITLEN  = pasta_pkg::BITLEN,
  parameter int unsigned Q       = pasta_pkg::Q,
  parameter int unsigned PASTA_S = pasta_pkg::PASTA_S,
  parameter int unsigned LANES   = 8
) (
  input  logic                      clk,
  input  logic                      rst_rc,
  input  logic                      start_rc,
  input  logic                      mode_rc,
  input  logic [BITLEN*PASTA_S-1:0] vec_in,
  input  logic [BITLEN*PASTA_S-1:0] in_rc,
  output logic [BITLEN*PASTA_S-1:0] out_rc,
  output logic                      busy_rc,
  output logic                      done_rc
);

  import pasta_pkg::*;

  localparam int unsigned NCHUNK = PASTA_S / LANES;
  localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

  if (LANES == 0 || (PASTA_S % LANES) != 0) begin : g_bad_lanes
    $error("round_constant_seq: LANES must divide PASTA_S");
  end

  rc_state_t                 state;
  logic [CNT_W-1:0]          cnt;
  logic [BITLEN*PASTA_S-1:0] vec_q;
  logic [BITLEN*PASTA_S-1:0] rc_q;
  logic                      mode_q;

  logic [BITLEN-1:0] a_sel  [LANES];
  logic [BITLEN-1:0] b_sel  [LANES];
  logic [BITLEN-1:0] r_lane [LANES];

  // Select the current chunk's lanes from the latched operands
  always_comb begin
    for (int unsigned j = 0; j < LANES; j++) begin
      a_sel[j] = vec_q[(32'(cnt) * LANES + j) * BITLEN +: BITLEN];
      b_sel[j] = rc_q[(32'(cnt) * LANES + j) * BITLEN +: BITLEN];
    end
  end

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    mod_addsub_lane #(
      .BITLEN(BITLEN),
      .Q     (Q)
    ) u_lane (
      .a   (a_sel[j]),
      .b   (b_sel[j]),
      .mode(mode_q),
      .r   (r_lane[j])
    );
  end

  always_ff @(posedge clk) begin
    if (rst_rc) begin
      state   <= IDLE;
      cnt     <= '0;
      vec_q   <= '0;
      rc_q    <= '0;
      mode_q  <= 1'b0;
      out_rc  <= '0;
      busy_rc <= 1'b0;
      done_rc <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          done_rc <= 1'b0;
          if (start_rc) begin
            vec_q   <= vec_in;
            rc_q    <= in_rc;
            mode_q  <= mode_rc;
            cnt     <= '0;
            busy_rc <= 1'b1;
            state   <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          for (int unsigned j = 0; j < LANES; j++) begin
            out_rc[(32'(cnt) * LANES + j) * BITLEN +: BITLEN] <= r_lane[j];
          end
          if (cnt == LAST) begin
            cnt     <= '0;
            busy_rc <= 1'b0;
            done_rc <= 1'b1;
            state   <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_round_constant_seq.sv
// Self-checking bench for round_constant_seq at LANES = 8, 32 and 1.
// All three instances share the stimulus; the suite is run against each in turn.
module tb_round_constant_seq;
  import pasta_pkg::*;

  localparam int unsigned VW = BITLEN * PASTA_S;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_rc, start_rc, mode_rc;
  logic [VW-1:0] vec_in, in_rc;
  logic [VW-1:0] out8, out32, out1;
  logic          busy8, busy32, busy1, done8, done32, done1;

  round_constant_seq #(.BITLEN(BITLEN), .Q(Q), .PASTA_S(PASTA_S), .LANES(8)) u_dut8 (
    .clk(clk), .rst_rc(rst_rc), .start_rc(start_rc), .mode_rc(mode_rc), .vec_in(vec_in),
    .in_rc(in_rc), .out_rc(out8), .busy_rc(busy8), .done_rc(done8));
  round_constant_seq #(.BITLEN(BITLEN), .Q(Q), .PASTA_S(PASTA_S), .LANES(32)) u_dut32 (
    .clk(clk), .rst_rc(rst_rc), .start_rc(start_rc), .mode_rc(mode_rc), .vec_in(vec_in),
    .in_rc(in_rc), .out_rc(out32), .busy_rc(busy32), .done_rc(done32));
  round_constant_seq #(.BITLEN(BITLEN), .Q(Q), .PASTA_S(PASTA_S), .LANES(1)) u_dut1 (
    .clk(clk), .rst_rc(rst_rc), .start_rc(start_rc), .mode_rc(mode_rc), .vec_in(vec_in),
    .in_rc(in_rc), .out_rc(out1), .busy_rc(busy1), .done_rc(done1));

  int            sel = 0;
  logic [VW-1:0] obs_out;
  logic          obs_busy, obs_done;

  always_comb begin
    obs_out  = out8;
    obs_busy = busy8;
    obs_done = done8;
    case (sel)
      1: begin obs_out = out32; obs_busy = busy32; obs_done = done32; end
      2: begin obs_out = out1;  obs_busy = busy1;  obs_done = done1;  end
      default: ;
    endcase
  end

  int ncomp = 0;
  int nfail = 0;
  int unsigned lanes, nch;
  int unsigned a_v [PASTA_S];
  int unsigned b_v [PASTA_S];
  logic [VW-1:0] exp_cur, exp_old, exp_new;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bit(input string tag, input logic got, input logic exp);
    ncomp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s (lanes=%0d): observed %b expected %b", tag, lanes, got, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    ncomp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s (lanes=%0d): observed %h expected %h", tag, lanes, got, exp);
    end
  endtask

  function automatic int unsigned ref_lane(input int unsigned a, input int unsigned b,
                                           input logic m);
    return m ? (a + Q - b) % Q : (a + b) % Q;
  endfunction

  task automatic scramble_inputs();
    for (int i = 0; i < PASTA_S; i++) begin
      vec_in[i*BITLEN +: BITLEN] = BITLEN'($urandom);
      in_rc[i*BITLEN +: BITLEN]  = BITLEN'($urandom);
    end
    mode_rc = 1'($urandom);
  endtask

  task automatic rand_operands();
    for (int i = 0; i < PASTA_S; i++) begin
      a_v[i] = $urandom_range(Q - 1, 0);
      b_v[i] = $urandom_range(Q - 1, 0);
    end
  endtask

  // Present a_v/b_v with mode m, pulse start for one edge, then disturb the inputs
  task automatic launch(input logic m);
    for (int i = 0; i < PASTA_S; i++) begin
      vec_in[i*BITLEN +: BITLEN]  = BITLEN'(a_v[i]);
      in_rc[i*BITLEN +: BITLEN]   = BITLEN'(b_v[i]);
      exp_new[i*BITLEN +: BITLEN] = BITLEN'(ref_lane(a_v[i], b_v[i], m));
    end
    exp_old  = exp_cur;
    mode_rc  = m;
    start_rc = 1'b1;
    step();
    start_rc = 1'b0;
    scramble_inputs();
    chk_bit("busy_after_start", obs_busy, 1'b1);
    chk_bit("no_done_after_start", obs_done, 1'b0);
  endtask

  // Walk the RUN phase: after k edges the first k*lanes lanes hold new results
  task automatic finish_op(input string tag);
    logic [VW-1:0] pv;
    for (int unsigned k = 1; k <= nch; k++) begin
      start_rc = 1'($urandom);
      step();
      for (int unsigned i = 0; i < PASTA_S; i++)
        pv[i*BITLEN +: BITLEN] = (i < k * lanes) ? lane_of(exp_new, i) : lane_of(exp_old, i);
      chk_vec(tag, obs_out, pv);
      chk_bit("done_timing", obs_done, k == nch);
      chk_bit("busy_timing", obs_busy, k != nch);
    end
    start_rc = 1'b0;
    exp_cur  = exp_new;
  endtask

  task automatic idle_check();
    step();
    chk_bit("done_single_pulse", obs_done, 1'b0);
    chk_bit("idle_not_busy", obs_busy, 1'b0);
    chk_vec("out_stable", obs_out, exp_cur);
  endtask

  task automatic run_suite();
    // Reset
    rst_rc = 1'b1; start_rc = 1'b0;
    repeat (3) step();
    chk_vec("reset_out", obs_out, '0);
    chk_bit("reset_busy", obs_busy, 1'b0);
    chk_bit("reset_done", obs_done, 1'b0);
    rst_rc  = 1'b0;
    exp_cur = '0;

    // Add wrap to zero
    for (int i = 0; i < PASTA_S; i++) begin a_v[i] = 65536; b_v[i] = 1; end
    launch(1'b0); finish_op("add_wrap_zero"); idle_check();

    // Add max + max
    for (int i = 0; i < PASTA_S; i++) begin a_v[i] = 65536; b_v[i] = 65536; end
    launch(1'b0); finish_op("add_max_max"); idle_check();

    // Add small values per lane
    for (int i = 0; i < PASTA_S; i++) begin a_v[i] = i; b_v[i] = 100; end
    launch(1'b0); finish_op("add_index"); idle_check();

    // Subtract boundary cases, rotated across lanes
    for (int i = 0; i < PASTA_S; i++) begin
      case (i % 3)
        0: begin a_v[i] = 0;     b_v[i] = 1;     end
        1: begin a_v[i] = 5;     b_v[i] = 3;     end
        default: begin a_v[i] = 40000; b_v[i] = 40000; end
      endcase
    end
    launch(1'b1); finish_op("sub_boundary"); idle_check();

    // Back-to-back: second start accepted in the DONE cycle
    rand_operands(); launch(1'b0); finish_op("b2b_first");
    rand_operands(); launch(1'b1); finish_op("b2b_second"); idle_check();

    // Reset in the middle of RUN
    rand_operands(); launch(1'b0);
    if (nch >= 2) step();
    rst_rc = 1'b1;
    step();
    rst_rc = 1'b0;
    chk_vec("abort_out", obs_out, '0);
    chk_bit("abort_busy", obs_busy, 1'b0);
    chk_bit("abort_done", obs_done, 1'b0);
    exp_cur = '0;
    for (int unsigned k = 0; k < nch + 2; k++) begin
      step();
      chk_bit("abort_no_done", obs_done, 1'b0);
    end

    // Reset and start together: start is dropped
    rand_operands();
    for (int i = 0; i < PASTA_S; i++) begin
      vec_in[i*BITLEN +: BITLEN] = BITLEN'(a_v[i]);
      in_rc[i*BITLEN +: BITLEN]  = BITLEN'(b_v[i]);
    end
    rst_rc = 1'b1; start_rc = 1'b1;
    step();
    rst_rc = 1'b0; start_rc = 1'b0;
    chk_bit("rst_start_busy", obs_busy, 1'b0);
    step();
    chk_bit("rst_start_idle_busy", obs_busy, 1'b0);
    chk_bit("rst_start_idle_done", obs_done, 1'b0);

    // Fresh random operations
    for (int n = 0; n < 3; n++) begin
      rand_operands(); launch(1'($urandom)); finish_op("random_op"); idle_check();
    end
  endtask

  initial begin
    rst_rc = 1'b1; start_rc = 1'b0; mode_rc = 1'b0;
    vec_in = '0; in_rc = '0;
    exp_cur = '0; exp_old = '0; exp_new = '0;
    for (int s = 0; s < 3; s++) begin
      sel   = s;
      lanes = (s == 0) ? 8 : (s == 1) ? 32 : 1;
      nch   = PASTA_S / lanes;
      run_suite();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
